// File: rtl/mult_seq_32bit_pkg.sv
// rtl/mult_seq_32bit_pkg.sv - shared state encodings, counter sizing and magnitude helper
package mult_seq_32bit_pkg;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude as unsigned; 0x80000000 maps to itself.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/LAC_32bit.sv
// rtl/LAC_32bit.sv - 32-bit lookahead adder built from 4-bit generate/propagate groups
module LAC_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic cg;
        logic gg;
        logic pg;
        logic cb;
        c  = '0;
        cg = cin;
        for (int grp = 0; grp < 8; grp++) begin
            gg = 1'b0;
            pg = 1'b1;
            cb = cg;
            for (int k = 0; k < 4; k++) begin
                c[grp*4+k] = cb;
                cb = g[grp*4+k] | (p[grp*4+k] & cb);
                gg = g[grp*4+k] | (p[grp*4+k] & gg);
                pg = pg & p[grp*4+k];
            end
            // Group carry-out comes from group G/P, not the in-group chain.
            cg = gg | (pg & cg);
        end
        cout = cg;
    end

    assign s = p ^ c;

endmodule

// File: rtl/mult_seq_32bit.sv
// rtl/mult_seq_32bit.sv - shift-add MULT/MULTU unit producing HI/LO over 32 iterations
module mult_seq_32bit
    import mult_seq_32bit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [31:0]      mcand;
    logic [31:0]      acc_hi;
    logic [31:0]      acc_lo;
    logic             neg;

    logic [31:0] add_b;
    logic [31:0] sum;
    logic        carry;
    logic [63:0] shifted;
    logic [63:0] product;
    logic        last;

    assign add_b = acc_lo[0] ? mcand : 32'd0;

    LAC_32bit u_lac (
        .s    (sum),
        .cout (carry),
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0)
    );

    // 65-bit {cout, sum, acc_lo} shifted right by one, low 64 bits kept.
    assign shifted = {carry, sum, acc_lo[31:1]};
    assign product = neg ? (~shifted + 64'd1) : shifted;
    assign last    = (count == ITER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == ST_IDLE && start) begin
            mcand  <= is_signed ? mag32(a) : a;
            acc_hi <= '0;
            acc_lo <= is_signed ? mag32(b) : b;
            neg    <= is_signed & (a[31] ^ b[31]);
            count  <= '0;
        end else if (state == ST_RUN) begin
            {acc_hi, acc_lo} <= shifted;
            count            <= count + 5'd1;
            if (last) {hi, lo} <= product;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mult_seq_32bit.sv
// tb/tb_mult_seq_32bit.sv - directed and reference-product checks for mult_seq_32bit
module tb_mult_seq_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    mult_seq_32bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE; returns edges from E0 to done and busy-cycle count.
    task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcyc);
        start = 1'b1; is_signed = sgn; a = x; b = y;
        tick();
        start = 1'b0;
        lat = 0; bcyc = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            tick();
            lat++;
        end
        if (done && busy) bcyc++;
    endtask

    task automatic finish_op(input string tag);
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    typedef struct {
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int lat;
        int bcyc;
        int quiet;
        logic [63:0] prev;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        tick(); tick();
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        tick();

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
        vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4] = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};

        foreach (vecs[i]) begin
            run_op(vecs[i].sgn, vecs[i].x, vecs[i].y, lat, bcyc);
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("dir%0d_busy_cycles", i), 64'(bcyc), 64'd33);
            check($sformatf("dir%0d_hilo", i), {hi, lo}, vecs[i].exp);
            finish_op($sformatf("dir%0d", i));
        end

        // Starts during RUN and in the DONE cycle must be ignored.
        start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        check("busy_start_done_seen", {63'd0, done}, 64'd1);
        start = 1'b1; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0;
        check("busy_start_hilo", {hi, lo}, 64'd15);
        check("done_start_ignored", {63'd0, busy}, 64'd0);
        run_op(1'b0, 32'd9, 32'd9, lat, bcyc);
        check("next_idle_hilo", {hi, lo}, 64'd81);
        finish_op("next_idle");

        // Asynchronous abort mid-run.
        start = 1'b1; is_signed = 1'b0; a = 32'h12345678; b = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        tick();
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) quiet++;
            tick();
        end
        check("abort_no_done", 64'(quiet), 64'd0);
        run_op(1'b1, 32'hFFFFFFFF, 32'd0, lat, bcyc);
        check("neg_zero_latency", 64'(lat), 64'd32);
        check("neg_zero_hilo", {hi, lo}, 64'd0);
        finish_op("neg_zero");

        prev = {hi, lo};
        for (int k = 0; k < 1000; k++) begin
            logic        sgn;
            logic [31:0] x;
            logic [31:0] y;
            sgn = 1'($urandom);
            x = $urandom;
            y = $urandom;
            start = 1'b1; is_signed = sgn; a = x; b = y;
            tick();
            start = 1'b0;
            a = $urandom; b = $urandom; is_signed = ~sgn;
            lat = 0;
            while (!done && lat < 40) begin
                if ({hi, lo} !== prev) break;
                tick();
                lat++;
            end
            check($sformatf("rnd%0d_hold", k), {63'd0, ({hi, lo} === prev) || done}, 64'd1);
            if (!done) begin
                while (!done && lat < 40) begin tick(); lat++; end
            end
            check($sformatf("rnd%0d_latency", k), 64'(lat), 64'd32);
            check($sformatf("rnd%0d_hilo", k), {hi, lo}, ref_prod(sgn, x, y));
            prev = ref_prod(sgn, x, y);
            finish_op($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_32bit.md
Name: mult_seq_32bit

Overview:
- Multi-cycle 32x32 -> 64-bit shift-add multiplier for the MIPS datapath, implementing MULT (signed) and MULTU (unsigned).
- Sits beside the ALU. It feeds operands into one 32-bit lookahead adder instance and consumes that adder's sum and carry, one partial product per cycle.
- Results land in HI/LO registers that the datapath reads with MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width. Fixed at 32 to match the adder; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- a  input  32  multiplicand; sampled with start
- b  input  32  multiplier; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; hi/lo valid from this cycle
- hi  output  32  upper 32 bits of product
- lo  output  32  lower 32 bits of product

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, hi=0, lo=0; count=0; all internal registers cleared. Reset mid-operation aborts the operation immediately, and the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge (load):
  - mcand <= |a| when is_signed, else a.
  - acc_hi <= 0; acc_lo <= |b| when is_signed, else b.
  - neg <= is_signed & (a[31]^b[31]).
  - count <= 0; go to RUN.
  - |x| is the two's-complement magnitude as unsigned 32-bit, so |0x80000000| = 0x80000000.
- RUN, each edge (iteration):
  - Adder inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0), cin=0.
  - {acc_hi, acc_lo} <= {cout, s, acc_lo} >> 1, i.e. a 65-bit right shift keeping the low 64 bits.
  - count <= count+1.
  - When count==31 this edge completes the final iteration. On the same edge: {hi,lo} <= neg ? (~P + 1) : P, where P is the 64-bit post-shift accumulator value, computed combinationally. Then go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start sampled at edge E0; 32 RUN edges E1..E32; done high during the cycle following E32. hi/lo are updated at E32.
- busy=1 from the cycle after the E0 edge through the DONE cycle inclusive.
- Busy/held conditions:
  - start while busy (RUN or DONE) is ignored; no queuing.
  - a, b, is_signed may change freely after E0.
  - hi/lo hold their value until the next completion. They are not cleared on start, only on reset.
- Back-to-back: start asserted in the DONE cycle is ignored. The earliest next accept is the first IDLE cycle.
- Negation of a zero product yields zero, e.g. signed -1*0.
- The adder is the only carry-propagating adder used for iterations. The final 64-bit negate and the input magnitude negation may use local incrementers.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - ITER_LAST=5'd31;
  - counter width 5.
- Sub-module: one instance of the existing LAC_32bit (ports s, cout, a, b, cin). No other sub-modules; sequencing and HI/LO live in this block.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done one cycle after E32; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
2. MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Also a=0x00000007, b=0xFFFFFFFD gives the same result.
3. MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. MULTU of the same operands -> hi=0x40000000, lo=0x00000000. MULT a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
4. Start MULTU 3*5. Pulse start with a=9, b=9 at cycles 5 and 33 (the DONE cycle) -> both ignored. hi=0, lo=15. A new start in the next IDLE cycle gives lo=81.
5. Start MULTU 0x12345678*0x9ABCDEF0; assert rst for one cycle at RUN iteration 10 -> busy=0, done=0, hi=lo=0 asynchronously. done never pulses for the aborted op. A subsequent MULT -1*0 gives hi=lo=0 with done pulsing once.
6. Randomized 1000 ops, mixed is_signed, compared against a 64-bit reference product -> exact match. done pulses once per op. hi/lo are stable between completions.
